victim_cache_tag: RTL

- Tag, valid and dirty store plus control FSM for the fully-associative victim cache.
- Sits directly upstream of the victim cache data array and drives its way select and write-enable.
- Services L1 miss lookups. On a hit, the line is handed back to L1 and the entry invalidated.
- Accepts lines evicted from L1. When it has to displace a valid dirty line to make room, it hands that line to the write-back path before overwriting.

---
 rtl/cache_def.sv | 21 ++
 rtl/victim_cache_tag_if.sv | 34 +++
 rtl/vc_way_select.sv | 37 +++
 rtl/victim_cache_tag.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared sizing, data-array request type and FSM state encoding for the
// victim cache tag/control block.
package cache_def;

    localparam int WAYS_VC      = 4;
    localparam int INDEX_WAY_VC = $clog2(WAYS_VC);
    localparam int TAG_VC_W     = 28;

    // Request into the victim cache data array.
    typedef struct packed {
        logic we;
    } vc_cache_req_type;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LK_RESP = 2'd1,
        EVICT   = 2'd2,
        WRITE   = 2'd3
    } vc_state_e;

endpackage

// File: rtl/victim_cache_tag_if.sv
// Lookup, insert, eviction and data-array signals between the victim cache
// tag block (slave) and its L1/memory-side environment (master).
interface victim_cache_tag_if;
    import cache_def::*;

    logic                    ready_o;
    logic                    lk_valid_i;
    logic [TAG_VC_W-1:0]     lk_tag_i;
    logic                    lk_done_o;
    logic                    lk_hit_o;
    logic [INDEX_WAY_VC-1:0] lk_way_o;
    logic                    ins_valid_i;
    logic [TAG_VC_W-1:0]     ins_tag_i;
    logic                    ins_dirty_i;
    logic                    ins_done_o;
    logic                    evict_valid_o;
    logic [TAG_VC_W-1:0]     evict_tag_o;
    logic                    evict_ready_i;
    vc_cache_req_type        data_req_o;
    logic [INDEX_WAY_VC-1:0] address_way_tag2data_o;

    modport slave (
        input  lk_valid_i, lk_tag_i, ins_valid_i, ins_tag_i, ins_dirty_i, evict_ready_i,
        output ready_o, lk_done_o, lk_hit_o, lk_way_o, ins_done_o,
               evict_valid_o, evict_tag_o, data_req_o, address_way_tag2data_o
    );

    modport master (
        output lk_valid_i, lk_tag_i, ins_valid_i, ins_tag_i, ins_dirty_i, evict_ready_i,
        input  ready_o, lk_done_o, lk_hit_o, lk_way_o, ins_done_o,
               evict_valid_o, evict_tag_o, data_req_o, address_way_tag2data_o
    );

endinterface

// File: rtl/vc_way_select.sv
// Combinational way search: tag match vector with hit encoder, plus the
// lowest-index invalid way. One instance serves both lookup and insert.
module vc_way_select
    import cache_def::*;
(
    input  logic [WAYS_VC-1:0][TAG_VC_W-1:0] tags,
    input  logic [WAYS_VC-1:0]               valid,
    input  logic [TAG_VC_W-1:0]              cmp_tag,
    output logic                             hit,
    output logic [INDEX_WAY_VC-1:0]          hit_way,
    output logic                             free,
    output logic [INDEX_WAY_VC-1:0]          free_way
);

    logic [WAYS_VC-1:0] match;

    // Per-way tag comparison, only valid entries can match.
    always_comb begin
        match = '0;
        for (int i = 0; i < WAYS_VC; i++) begin
            match[i] = valid[i] && (tags[i] == cmp_tag);
        end
    end

    // Encode the matching way and the lowest-index invalid way (low index wins).
    always_comb begin
        hit      = |match;
        free     = ~&valid;
        hit_way  = '0;
        free_way = '0;
        for (int i = WAYS_VC - 1; i >= 0; i--) begin
            hit_way  = match[i]  ? INDEX_WAY_VC'(i) : hit_way;
            free_way = !valid[i] ? INDEX_WAY_VC'(i) : free_way;
        end
    end

endmodule

// File: rtl/victim_cache_tag.sv
// Tag/valid/dirty store and control FSM of the fully-associative victim
// cache. Drives way select and write enable of the downstream data array.
module victim_cache_tag
    import cache_def::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    victim_cache_tag_if.slave bus
);

    localparam logic [INDEX_WAY_VC-1:0] WAY_ONE = INDEX_WAY_VC'(1);

    vc_state_e                        state;
    vc_state_e                        next_state;
    logic [WAYS_VC-1:0][TAG_VC_W-1:0] tag_mem;
    logic [WAYS_VC-1:0]               valid;
    logic [WAYS_VC-1:0]               dirty;
    logic [INDEX_WAY_VC-1:0]          rr_ptr;
    logic [INDEX_WAY_VC-1:0]          way;       // lookup result or insert target
    logic                             lk_hit;
    logic [TAG_VC_W-1:0]              ins_tag;
    logic                             ins_dirty; // dirty value to store on write
    logic                             use_ptr;   // target came from round-robin

    logic [TAG_VC_W-1:0]     cmp_tag;
    logic                    any_hit;
    logic [INDEX_WAY_VC-1:0] hit_way;
    logic                    any_free;
    logic [INDEX_WAY_VC-1:0] free_way;
    logic [INDEX_WAY_VC-1:0] tgt_way;
    logic                    tgt_dirty;
    logic                    tgt_ptr;
    logic                    tgt_evict;

    // Insert has priority in IDLE, so it owns the shared comparator then.
    assign cmp_tag = bus.ins_valid_i ? bus.ins_tag_i : bus.lk_tag_i;

    vc_way_select u_way_select (
        .tags     (tag_mem),
        .valid    (valid),
        .cmp_tag  (cmp_tag),
        .hit      (any_hit),
        .hit_way  (hit_way),
        .free     (any_free),
        .free_way (free_way)
    );

    // Insert target: matching way, else first invalid way, else round-robin victim.
    always_comb begin
        tgt_way   = rr_ptr;
        tgt_dirty = bus.ins_dirty_i;
        tgt_ptr   = 1'b0;
        tgt_evict = 1'b0;
        if (any_hit) begin
            tgt_way   = hit_way;
            tgt_dirty = dirty[hit_way] | bus.ins_dirty_i;
        end else if (any_free) begin
            tgt_way   = free_way;
        end else begin
            tgt_ptr   = 1'b1;
            tgt_evict = valid[rr_ptr] & dirty[rr_ptr];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.ins_valid_i) begin
                    next_state = tgt_evict ? EVICT : WRITE;
                end else if (bus.lk_valid_i) begin
                    next_state = LK_RESP;
                end else begin
                    next_state = IDLE;
                end
            end
            LK_RESP: next_state = IDLE;
            EVICT: begin
                if (bus.evict_ready_i) begin
                    next_state = WRITE;
                end else begin
                    next_state = EVICT;
                end
            end
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Tag store, request capture, hit invalidation and round-robin update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid     <= '0;
            dirty     <= '0;
            rr_ptr    <= '0;
            way       <= '0;
            lk_hit    <= 1'b0;
            ins_tag   <= '0;
            ins_dirty <= 1'b0;
            use_ptr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ins_valid_i) begin
                        ins_tag   <= bus.ins_tag_i;
                        ins_dirty <= tgt_dirty;
                        way       <= tgt_way;
                        use_ptr   <= tgt_ptr;
                    end else if (bus.lk_valid_i) begin
                        lk_hit <= any_hit;
                        way    <= any_hit ? hit_way : '0;
                    end
                end
                LK_RESP: begin
                    // Line moves back to L1, so the entry is released.
                    if (lk_hit) begin
                        valid[way] <= 1'b0;
                        dirty[way] <= 1'b0;
                    end
                end
                WRITE: begin
                    tag_mem[way] <= ins_tag;
                    valid[way]   <= 1'b1;
                    dirty[way]   <= ins_dirty;
                    if (use_ptr) begin
                        rr_ptr <= rr_ptr + WAY_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State-decoded outputs towards L1, memory and the data array.
    always_comb begin
        bus.ready_o                = 1'b0;
        bus.lk_done_o              = 1'b0;
        bus.lk_hit_o               = 1'b0;
        bus.lk_way_o               = '0;
        bus.ins_done_o             = 1'b0;
        bus.evict_valid_o          = 1'b0;
        bus.evict_tag_o            = '0;
        bus.data_req_o             = '0;
        bus.address_way_tag2data_o = '0;
        case (state)
            IDLE: bus.ready_o = 1'b1;
            LK_RESP: begin
                bus.lk_done_o              = 1'b1;
                bus.lk_hit_o               = lk_hit;
                bus.lk_way_o               = way;
                bus.address_way_tag2data_o = way;
            end
            EVICT: begin
                bus.evict_valid_o          = 1'b1;
                bus.evict_tag_o            = tag_mem[way];
                bus.address_way_tag2data_o = way;
            end
            WRITE: begin
                bus.data_req_o.we          = 1'b1;
                bus.ins_done_o             = 1'b1;
                bus.address_way_tag2data_o = way;
            end
            default: bus.ready_o = 1'b0;
        endcase
    end

endmodule
